rs_pipeline_sequencer: RTL
==========================

Name: rs_pipeline_sequencer

Overview:
- Controller for the four-stage Reed-Solomon decode pipeline: syndrome, Berlekamp-Massey, root search, Forney.
- Tracks which stage holds a block and accepts a new codeword from the host buffer via a valid/ready handshake.
- Advances all stages together once every occupied stage reports done, and issues per-stage start pulses.
- Presents the decoded block to the host with out_valid/out_ready, stalls while a result is unconsumed, and enforces a per-step watchdog timeout.

Parameters:
- NUM_STAGES, 4: pipeline depth; stage 0 = syndrome, stage NUM_STAGES-1 = Forney.
- START_HOLDOFF, 2: cycles after a start pulse during which stage_done is ignored, to cover stale done from the previous block. Must be 1..7.
- TIMEOUT_CYCLES, 4096: maximum cycles in RUN without an advance before a fault.
- TMR_W, 13: watchdog counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host buffer holds a new codeword.
- in_ready  out  1  codeword accepted this cycle if in_valid.
- stage_done  in  NUM_STAGES  per-stage done from the datapath.
- stage_start  out  NUM_STAGES  one-cycle start/reset pulse per stage.
- occ  out  NUM_STAGES  stage occupancy.
- out_valid  out  1  Forney result valid.
- out_ready  in  1  host has consumed the result.
- flush  in  1  abort all blocks; one-cycle pulse.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky fault flag.
- irq  out  1  out_valid | timeout.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, occ=0, stage_start=0, holdoff=0, retired=0, wdog=0, timeout=0. All outputs read 0 except in_ready=1.
- States: IDLE, RUN, FAULT.
- Qualified done: qd[i] = !occ[i] | (stage_done[i] & holdoff==0).
- adv_ok = (state==IDLE) | (state==RUN & &qd & (!occ[NUM_STAGES-1] | retired)).
- in_ready = adv_ok. It is combinational from registers only and never depends on in_valid.
- advance = adv_ok & (in_valid | |occ[NUM_STAGES-2:0]).
- On advance at cycle t:
  - occ <= {occ[NUM_STAGES-2:0], in_valid}; retired <= 0; wdog <= 0; holdoff <= START_HOLDOFF.
  - stage_start <= new occ, so the pulse is visible only at cycle t+1.
  - state <= RUN.
- In RUN without advance: holdoff decrements toward 0, wdog increments, stage_start=0.
- Minimum advance interval is START_HOLDOFF+1 cycles.
- out_valid = state==RUN & occ[NUM_STAGES-1] & qd[NUM_STAGES-1] & !retired.
- out_valid & out_ready sets retired=1. The handshake and the resulting advance can never fall in the same cycle.
- Idle transition: in RUN, if &qd, the last stage is empty or retired, occ[NUM_STAGES-2:0]==0 and in_valid=0, then next state = IDLE and occ <= 0.
- Watchdog: in RUN, if wdog==TIMEOUT_CYCLES-1 and some occupied stage has qd=0, then:
  - state <= FAULT, timeout <= 1, occ <= 0.
  - Waiting on out_ready does not count as stuck; wdog holds while only out_valid is pending.
- FAULT: in_ready=0, out_valid=0, stage_start=0. Leaves only on flush or rst.
- flush (any state) has the same effect as rst, including clearing timeout. flush has priority over advance and handshake in the same cycle.
- in_valid arriving while in_ready=0 is held by the source; no loss.

Optional Feature:
- RS_SEQ_STATS_EN defined:
  - Adds output blocks_done[15:0], incremented on each out_valid&out_ready and wrapping at 0xFFFF->0.
  - Adds output stall_cycles[15:0], incremented on each cycle with out_valid & !out_ready, saturating at 0xFFFF.
  - Both are cleared by rst or flush.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Package rs_decoder_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, FAULT=2'd2;
  - NUM_STAGES and the stage index constants STG_SYN=0, STG_BM=1, STG_ROOT=2, STG_FORNEY=3.
- Sub-module rs_stage_watchdog holds the wdog counter, clear/enable inputs and the expiry compare.

Test Plan:
- Basic fill: after reset, in_valid=1 continuously and stage_done=4'hF.
  - Advances occur at cycles 0, 3, 6, 9.
  - stage_start = 0001, 0011, 0111, 1111 on cycles 1, 4, 7, 10.
  - out_valid first rises at cycle 12.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - in_ready=0, occ frozen at 1111, no stage_start, timeout stays 0.
  - One out_ready pulse gives advance 1 cycle later.
- Holdoff: stage_done=1 continuously.
  - Done is not honoured on cycles t+1 and t+2 after an advance; the next advance occurs at t+3, not earlier.
- Drain: a single block with in_valid then 0.
  - occ walks 0001, 0010, 0100, 1000.
  - After out_ready, state returns to IDLE with busy=0.
- Timeout: TIMEOUT_CYCLES=16, stage_done[1] held 0 with occ[1]=1.
  - Exactly 16 cycles after the advance: timeout=1, irq=1, occ=0, in_ready=0.
  - flush then gives IDLE, in_ready=1, timeout=0.
- Flush and reset mid-run: flush asserted together with an advance condition.
  - No stage_start pulse, occ=0.
  - rst mid-run gives the same result; with RS_SEQ_STATS_EN, blocks_done=0.

Source files
------------

// File: rtl/rs_decoder_pkg.sv
// Shared types and constants for the Reed-Solomon decode pipeline control.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state encoding, pipeline depth, stage index constants.
package rs_decoder_pkg;

    localparam int NUM_STAGES = 4;

    // Stage positions in the occupancy / start / done vectors.
    localparam int STG_SYN    = 0;
    localparam int STG_BM     = 1;
    localparam int STG_ROOT   = 2;
    localparam int STG_FORNEY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rs_stage_watchdog.sv
// Per-step watchdog: counts stuck cycles since the last pipeline advance.
// Latency: expired is a compare on the registered count (same cycle).
// Backpressure: none; the caller gates en so waiting on the host never counts.
// Ports: clk, rst (sync, active-high), clr (restart count), en (count this
//        cycle), expired (count has reached TIMEOUT_CYCLES-1).
module rs_stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] wdog;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wdog <= '0;
        end else if (en) begin
            wdog <= wdog + 1'b1;
        end
    end

    assign expired = (wdog == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rs_pipeline_sequencer.sv
// Sequencer for the syndrome / BM / root-search / Forney decode pipeline.
// Latency: stage_start pulses one cycle after an advance; out_valid once the last stage is done.
// Backpressure: in_ready drops while any occupied stage is busy or the result is unconsumed.
// Ports: clk, rst (sync, active-high); in_valid/in_ready host input handshake;
//        stage_done/stage_start per-stage datapath control; occ stage occupancy;
//        out_valid/out_ready result handshake; flush abort; busy, timeout, irq status.
// Optional: RS_SEQ_STATS_EN adds blocks_done and stall_cycles counters.
module rs_pipeline_sequencer #(
    parameter int NUM_STAGES     = rs_decoder_pkg::NUM_STAGES,
    parameter int START_HOLDOFF  = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [NUM_STAGES-1:0] occ,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic                  timeout,
    output logic                  irq
`ifdef RS_SEQ_STATS_EN
    ,
    output logic [15:0]           blocks_done,
    output logic [15:0]           stall_cycles
`endif
);

    import rs_decoder_pkg::*;

    seq_state_t            state;
    logic [2:0]            holdoff;
    logic                  retired;
    logic [NUM_STAGES-1:0] qd;
    logic [NUM_STAGES-1:0] occ_shift;
    logic                  adv_ok;
    logic                  advance;
    logic                  go_idle;
    logic                  stuck;
    logic                  wd_expired;

    // A done from a stage is only trusted once the holdoff after its start
    // pulse has elapsed; the datapath may still show done for the old block.
    assign qd = ~occ | (stage_done & {NUM_STAGES{holdoff == 3'd0}});

    assign adv_ok = (state == IDLE) ||
                    ((state == RUN) && (&qd) && (!occ[NUM_STAGES-1] || retired));

    // Advance only when something actually moves: a new block or an upstream one.
    assign advance = adv_ok && (in_valid || (|occ[NUM_STAGES-2:0]));

    // In RUN, a ready pipeline with nothing to move has fully drained.
    assign go_idle = (state == RUN) && adv_ok && !advance;

    // Stuck means an occupied stage has not finished; a pending result that
    // the host has not taken is not stuck, so the watchdog holds then.
    assign stuck = (state == RUN) && (|(occ & ~qd));

    always_comb begin
        occ_shift          = occ << 1;
        occ_shift[STG_SYN] = in_valid;
    end

    assign in_ready  = adv_ok;
    assign out_valid = (state == RUN) && occ[NUM_STAGES-1] && qd[NUM_STAGES-1] && !retired;
    assign busy      = (state != IDLE);
    assign irq       = out_valid || timeout;

    rs_stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst || flush),
        .clr     (advance),
        .en      (stuck),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= IDLE;
            occ         <= '0;
            stage_start <= '0;
            holdoff     <= '0;
            retired     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            stage_start <= '0;
            if (advance) begin
                occ         <= occ_shift;
                stage_start <= occ_shift;
                retired     <= 1'b0;
                holdoff     <= 3'(START_HOLDOFF);
                state       <= RUN;
            end else if (go_idle) begin
                occ     <= '0;
                retired <= 1'b0;
                state   <= IDLE;
            end else if (state == RUN) begin
                if (stuck && wd_expired) begin
                    state   <= FAULT;
                    timeout <= 1'b1;
                    occ     <= '0;
                end else begin
                    if (holdoff != 3'd0) begin
                        holdoff <= holdoff - 3'd1;
                    end
                    if (out_valid && out_ready) begin
                        retired <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RS_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            blocks_done  <= '0;
            stall_cycles <= '0;
        end else begin
            if (out_valid && out_ready) begin
                blocks_done <= blocks_done + 16'd1;
            end
            if (out_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
